branch_predictor_gshare: RTL and testbench
==========================================

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter GHR_BITS, default 8, meaning global history width and PHT index width (PHT depth 2^GHR_BITS).
REQ-002 SHALL have parameter CTR_BITS, default 2, meaning PHT saturating counter width (legal 2..4).
REQ-003 SHALL have parameter BTB_ENTRIES, default 16, meaning direct-mapped BTB depth (power of 2, at most 2^GHR_BITS).
REQ-004 SHALL have parameter DBITS, default 32, meaning PC/target width.
REQ-005 SHALL have ports, clock and reset first:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- lookup_pc  input  DBITS  fetch PC
- lookup_valid  input  1  fetch advances this cycle
- pred_taken  output  1  predicted taken
- pred_next_pc  output  DBITS  predicted next PC
- pred_index  output  GHR_BITS  PHT index used; carried down pipe
- pred_ghr  output  GHR_BITS  GHR checkpoint at lookup; carried down pipe
- ready  output  1  init done, predictions meaningful
- upd_valid  input  1  resolved control instruction from AGEX
- upd_cond  input  1  instruction is a conditional branch
- upd_pc  input  DBITS  resolved instruction PC
- upd_index  input  GHR_BITS  pred_index returned
- upd_ghr  input  GHR_BITS  pred_ghr returned
- upd_taken  input  1  actual outcome
- upd_target  input  DBITS  actual target
- upd_mispred  input  1  next PC was mispredicted

Function
REQ-006 SHALL compute lookup outputs combinationally from lookup_pc and current state; zero-cycle latency.
REQ-007 SHALL form pred_index = lookup_pc[GHR_BITS+1:2] XOR GHR.
REQ-008 SHALL index BTB with lookup_pc[log2(BTB_ENTRIES)+1:2]; tag = lookup_pc[DBITS-1:log2(BTB_ENTRIES)+2]; hit = valid AND tag match.
REQ-009 SHALL drive pred_taken = hit AND PHT[pred_index] MSB; pred_next_pc = BTB target if pred_taken, else lookup_pc+4 (mod 2^DBITS).
REQ-010 SHALL drive pred_ghr = current GHR.
REQ-011 SHALL implement FSM states INIT and RUN; reset enters INIT with init counter 0.
REQ-012 In INIT SHALL, each cycle, write PHT[cnt] = 2^(CTR_BITS-1)-1 (weakly not-taken), clear BTB valid[cnt] when cnt < BTB_ENTRIES, increment cnt; after writing entry 2^GHR_BITS-1, go to RUN next cycle.
REQ-013 In INIT SHALL drive ready=0, pred_taken=0, pred_next_pc=lookup_pc+4, and ignore upd_valid and lookup_valid.
REQ-014 In RUN SHALL drive ready=1; RUN is left only by reset.
REQ-015 On upd_valid in RUN with upd_taken=1 SHALL write BTB[upd_pc index] = {valid, upd_pc tag, upd_target}, overwriting any entry.
REQ-016 On upd_valid AND upd_cond in RUN SHALL increment PHT[upd_index] if upd_taken, else decrement, saturating at 2^CTR_BITS-1 and 0.
REQ-017 SHALL make table writes visible to lookups from the next cycle; same-cycle lookup sees old contents (no bypass).
REQ-018 Same-cycle lookup and update to the same entry SHALL be legal: write completes, lookup returns pre-write value.

Reset
REQ-019 reset SHALL set GHR=0, state=INIT, cnt=0; reset during INIT restarts at cnt=0; reset in RUN discards tables by re-running INIT.
REQ-020 SHALL complete initialisation in exactly 2^GHR_BITS cycles after reset deasserts; ready=1 on the following cycle.

Configuration
REQ-021 With BP_SPEC_GHR_EN undefined, GHR SHALL update only on upd_valid AND upd_cond in RUN: GHR <= {GHR[GHR_BITS-2:0], upd_taken}.
REQ-022 With BP_SPEC_GHR_EN defined, GHR SHALL shift in pred_taken when lookup_valid AND ready AND BTB hit.
REQ-023 With BP_SPEC_GHR_EN defined, on upd_valid AND upd_mispred SHALL restore GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken} if upd_cond, else GHR <= upd_ghr; non-mispredicted updates leave GHR unchanged.
REQ-024 With BP_SPEC_GHR_EN defined, mispredict recovery SHALL take priority over a same-cycle speculative shift.

Verification
REQ-025 Reset, defaults -> ready=0 for 256 cycles, ready=1 on cycle 257; any lookup gives pred_taken=0, pred_next_pc=PC+4.
REQ-026 RUN, upd pc=0x100, cond, taken, target 0x80, twice -> PHT entry 01->10->11; lookup 0x100 with matching GHR gives pred_taken=1, pred_next_pc=0x80.
REQ-027 Four taken updates then six not-taken updates on one index -> counter saturates at 11, then at 00; no wrap.
REQ-028 BTB alias: taken update pc=0x100, then pc=0x140 (same index, different tag) -> lookup 0x100 misses, pred_next_pc=0x104.
REQ-029 BP_SPEC_GHR_EN: GHR=0x00, BTB-hit lookup predicted taken -> GHR=0x01; same cycle mispred upd_ghr=0x0F, cond, not-taken -> GHR=0x1E.
REQ-030 Reset asserted at cnt=100 -> cnt restarts at 0; ready rises exactly 256 cycles after deassertion; tables fully reinitialised.

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: gshare conditional-direction predictor (global
// history XOR PC indexing a table of saturating counters) paired with a
// direct-mapped branch target buffer. Lookups are combinational; table
// writes land on the clock edge and are visible from the next cycle.
// After reset an INIT sweep rewrites every PHT entry to weakly not-taken
// and clears every BTB valid bit, one entry per cycle, before RUN.
// Optional build macro BP_SPEC_GHR_EN: the GHR is shifted speculatively
// at lookup and repaired from the returned checkpoint on a mispredict.
module branch_predictor_gshare #(
  parameter int GHR_BITS    = 8,
  parameter int CTR_BITS    = 2,
  parameter int BTB_ENTRIES = 16,
  parameter int DBITS       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    lookup_pc,
  input  logic                lookup_valid,
  output logic                pred_taken,
  output logic [DBITS-1:0]    pred_next_pc,
  output logic [GHR_BITS-1:0] pred_index,
  output logic [GHR_BITS-1:0] pred_ghr,
  output logic                ready,
  input  logic                upd_valid,
  input  logic                upd_cond,
  input  logic [DBITS-1:0]    upd_pc,
  input  logic [GHR_BITS-1:0] upd_index,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic [DBITS-1:0]    upd_target,
  input  logic                upd_mispred
);

  localparam int PHT_DEPTH    = 1 << GHR_BITS;
  localparam int BTB_IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_BITS     = DBITS - BTB_IDX_BITS - 2;

  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN     = '0;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t              r_state;
  logic [GHR_BITS-1:0] r_cnt;
  logic [GHR_BITS-1:0] r_ghr;
  logic                r_ready;

  logic [CTR_BITS-1:0] r_pht       [PHT_DEPTH];
  logic                r_btb_valid [BTB_ENTRIES];
  logic [TAG_BITS-1:0] r_btb_tag   [BTB_ENTRIES];
  logic [DBITS-1:0]    r_btb_tgt   [BTB_ENTRIES];

  logic                    w_run;
  logic [GHR_BITS-1:0]     w_lk_index;
  logic [BTB_IDX_BITS-1:0] w_lk_btb_idx;
  logic [TAG_BITS-1:0]     w_lk_tag;
  logic                    w_lk_hit;
  logic                    w_lk_taken;
  logic [DBITS-1:0]        w_lk_seq_pc;

  logic [BTB_IDX_BITS-1:0] w_upd_btb_idx;
  logic [TAG_BITS-1:0]     w_upd_tag;
  logic [CTR_BITS-1:0]     w_upd_ctr;
  logic [CTR_BITS-1:0]     w_upd_ctr_next;

  logic                    w_init_btb;
  logic [BTB_IDX_BITS-1:0] w_init_btb_idx;
  logic [GHR_BITS-1:0]     w_ghr_next;
  logic                    w_unused;

  assign w_run = (r_state == ST_RUN);

  // Lookup path: PHT index, BTB hit detection and next-PC selection.
  always_comb begin
    w_lk_index   = lookup_pc[GHR_BITS+1:2] ^ r_ghr;
    w_lk_btb_idx = lookup_pc[BTB_IDX_BITS+1:2];
    w_lk_tag     = lookup_pc[DBITS-1:BTB_IDX_BITS+2];
    w_lk_seq_pc  = lookup_pc + DBITS'(4);
    w_lk_hit     = r_btb_valid[w_lk_btb_idx] && (r_btb_tag[w_lk_btb_idx] == w_lk_tag);
    w_lk_taken   = w_run && w_lk_hit && r_pht[w_lk_index][CTR_BITS-1];
  end

  assign pred_taken   = w_lk_taken;
  assign pred_next_pc = w_lk_taken ? r_btb_tgt[w_lk_btb_idx] : w_lk_seq_pc;
  assign pred_index   = w_lk_index;
  assign pred_ghr     = r_ghr;
  assign ready        = r_ready;

  // Update path: BTB slot/tag of the resolved PC and the saturated counter value.
  always_comb begin
    w_upd_btb_idx = upd_pc[BTB_IDX_BITS+1:2];
    w_upd_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];
    w_upd_ctr     = r_pht[upd_index];
    if (upd_taken) begin
      w_upd_ctr_next = (w_upd_ctr == CTR_MAX) ? w_upd_ctr : w_upd_ctr + CTR_BITS'(1);
    end else begin
      w_upd_ctr_next = (w_upd_ctr == CTR_MIN) ? w_upd_ctr : w_upd_ctr - CTR_BITS'(1);
    end
  end

  // INIT sweep: only the first BTB_ENTRIES steps of the counter touch the BTB.
  always_comb begin
    w_init_btb     = ({1'b0, r_cnt} < (GHR_BITS+1)'(BTB_ENTRIES));
    w_init_btb_idx = r_cnt[BTB_IDX_BITS-1:0];
  end

  // Next global history value while running.
  always_comb begin
    w_ghr_next = r_ghr;
`ifdef BP_SPEC_GHR_EN
    // Repair from the checkpoint wins over a same-cycle speculative shift.
    if (upd_valid && upd_mispred) begin
      w_ghr_next = upd_cond ? {upd_ghr[GHR_BITS-2:0], upd_taken} : upd_ghr;
    end else if (lookup_valid && w_lk_hit) begin
      w_ghr_next = {r_ghr[GHR_BITS-2:0], w_lk_taken};
    end
`else
    if (upd_valid && upd_cond) begin
      w_ghr_next = {r_ghr[GHR_BITS-2:0], upd_taken};
    end
`endif
  end

`ifdef BP_SPEC_GHR_EN
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0], lookup_valid, upd_ghr, upd_mispred};
`endif

  // Control FSM: INIT sweep counter, RUN state, registered ready and GHR.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ghr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + GHR_BITS'(1);
          if (r_cnt == '1) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_ghr <= w_ghr_next;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Table writes: INIT sweep, or training from resolved instructions in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_pht[r_cnt] <= CTR_WEAK_NT;
        if (w_init_btb) begin
          r_btb_valid[w_init_btb_idx] <= 1'b0;
        end
      end else if (upd_valid) begin
        if (upd_cond) begin
          r_pht[upd_index] <= w_upd_ctr_next;
        end
        if (upd_taken) begin
          r_btb_valid[w_upd_btb_idx] <= 1'b1;
          r_btb_tag[w_upd_btb_idx]   <= w_upd_tag;
          r_btb_tgt[w_upd_btb_idx]   <= upd_target;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Testbench for branch_predictor_gshare (default parameters). Hand-computed
// vector table for training/saturation/aliasing, randomized traffic against
// a behavioural model, and reset-during-init / reset-during-run sequences.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        lookup_valid;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic [7:0]  pred_index;
  logic [7:0]  pred_ghr;
  logic        ready;
  logic        upd_valid, upd_cond, upd_taken, upd_mispred;
  logic [31:0] upd_pc, upd_target;
  logic [7:0]  upd_index, upd_ghr;

  always #5 clk = ~clk;

  branch_predictor_gshare #(
    .GHR_BITS(8), .CTR_BITS(2), .BTB_ENTRIES(16), .DBITS(32)
  ) dut (
    .clk(clk), .reset(reset),
    .lookup_pc(lookup_pc), .lookup_valid(lookup_valid),
    .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .pred_index(pred_index), .pred_ghr(pred_ghr), .ready(ready),
    .upd_valid(upd_valid), .upd_cond(upd_cond), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred)
  );

  typedef struct {
    logic [31:0] lk_pc;
    bit          lk_v;
    bit          uv, uc, ut, um;
    logic [31:0] upc, utgt;
    logic [7:0]  uidx, ughr;
    bit          e_tk;
    logic [31:0] e_npc;
    logic [7:0]  e_idx, e_ghr;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: whole tables, cleared at once on reset.
  int          m_pht  [256];
  bit          m_bv   [16];
  int unsigned m_btag [16];
  logic [31:0] m_btgt [16];
  int unsigned m_ghr;
  int          m_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
    m_ghr  = 0;
    m_wait = 256;
  endtask

  function automatic void mdl_pred(input logic [31:0] pc, output bit hit, output bit tk,
                                   output logic [31:0] npc, output int unsigned idx);
    int unsigned bi, tag;
    bi  = (pc / 4) % 16;
    tag = pc / 64;
    idx = ((pc / 4) ^ m_ghr) % 256;
    hit = m_bv[bi] && (m_btag[bi] == tag);
    tk  = (m_wait == 0) && hit && (m_pht[idx] >= 2);
    npc = tk ? m_btgt[bi] : pc + 32'd4;
  endfunction

  task automatic mdl_edge(input bit hit, input bit tk);
    int unsigned bi;
    if (m_wait > 0) begin
      m_wait--;
      return;
    end
`ifdef BP_SPEC_GHR_EN
    if (upd_valid && upd_mispred)
      m_ghr = upd_cond ? ((int'(upd_ghr) * 2 + int'(upd_taken)) % 256) : int'(upd_ghr);
    else if (lookup_valid && hit)
      m_ghr = (m_ghr * 2 + int'(tk)) % 256;
`else
    if (upd_valid && upd_cond) m_ghr = (m_ghr * 2 + int'(upd_taken)) % 256;
`endif
    if (upd_valid && upd_cond) begin
      if (upd_taken) m_pht[upd_index] = (m_pht[upd_index] < 3) ? m_pht[upd_index] + 1 : 3;
      else           m_pht[upd_index] = (m_pht[upd_index] > 0) ? m_pht[upd_index] - 1 : 0;
    end
    if (upd_valid && upd_taken) begin
      bi = (upd_pc / 4) % 16;
      m_bv[bi]   = 1'b1;
      m_btag[bi] = upd_pc / 64;
      m_btgt[bi] = upd_target;
    end
  endtask

  // One cycle: drive at the falling edge, sample 1ns later, advance the model at the rising edge.
  task automatic step(input vec_t v, input bit cmp_model, input bit cmp_exp,
                      input string tag, output bit rdy);
    bit hit, tk;
    logic [31:0] npc;
    int unsigned idx;
    lookup_pc = v.lk_pc;  lookup_valid = v.lk_v;
    upd_valid = v.uv;     upd_cond = v.uc;  upd_taken = v.ut;  upd_mispred = v.um;
    upd_pc = v.upc;       upd_target = v.utgt;
    upd_index = v.uidx;   upd_ghr = v.ughr;
    #1;
    rdy = ready;
    mdl_pred(v.lk_pc, hit, tk, npc, idx);
    if (cmp_model) begin
      chk({tag, " ready"}, ready, (m_wait == 0));
      chk({tag, " taken"}, pred_taken, tk);
      chk({tag, " next_pc"}, pred_next_pc, npc);
      chk({tag, " index"}, pred_index, idx);
      chk({tag, " ghr"}, pred_ghr, m_ghr);
    end
    if (cmp_exp) begin
      chk({tag, " ready"}, ready, 1);
      chk({tag, " taken"}, pred_taken, v.e_tk);
      chk({tag, " next_pc"}, pred_next_pc, v.e_npc);
      chk({tag, " index"}, pred_index, v.e_idx);
      chk({tag, " ghr"}, pred_ghr, v.e_ghr);
    end
    @(posedge clk);
    mdl_edge(hit, tk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lookup_valid = 1'b0;
    upd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
  endtask

  function automatic vec_t row(input logic [31:0] lk, input bit lkv, input bit uv, input bit uc,
                               input logic [31:0] upc, input logic [7:0] uidx, input bit ut,
                               input logic [31:0] utgt, input bit um, input logic [7:0] ughr,
                               input bit etk, input logic [31:0] enpc,
                               input logic [7:0] eidx, input logic [7:0] eghr);
    vec_t v;
    v.lk_pc = lk;  v.lk_v = lkv;  v.uv = uv;  v.uc = uc;  v.upc = upc;  v.uidx = uidx;
    v.ut = ut;     v.utgt = utgt; v.um = um;  v.ughr = ughr;
    v.e_tk = etk;  v.e_npc = enpc; v.e_idx = eidx; v.e_ghr = eghr;
    return v;
  endfunction

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v = row(rnd_pc(), bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 1)), rnd_pc(), 8'($urandom_range(0, 255)),
            bit'($urandom_range(0, 1)), 32'($urandom), ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)), 1'b0, 32'd0, 8'd0, 8'd0);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    bit   rdy;
    int   rise;

    reset = 1'b1;
    lookup_pc = '0; lookup_valid = 1'b0;
    upd_valid = 1'b0; upd_cond = 1'b0; upd_taken = 1'b0; upd_mispred = 1'b0;
    upd_pc = '0; upd_target = '0; upd_index = '0; upd_ghr = '0;
    @(negedge clk);
    do_reset();

`ifdef BP_SPEC_GHR_EN
    tbl.push_back(row(32'h0,   0, 1, 0, 32'h100, 8'h00, 1, 32'h80, 0, 8'h00, 0, 32'h4,   8'h00, 8'h00));
    tbl.push_back(row(32'h0,   0, 1, 1, 32'h100, 8'h40, 1, 32'h80, 0, 8'h00, 0, 32'h4,   8'h00, 8'h00));
    tbl.push_back(row(32'h0,   0, 1, 1, 32'h100, 8'h40, 1, 32'h80, 0, 8'h00, 0, 32'h4,   8'h00, 8'h00));
    tbl.push_back(row(32'h100, 1, 0, 0, 32'h0,   8'h00, 0, 32'h0,  0, 8'h00, 1, 32'h80,  8'h40, 8'h00));
    tbl.push_back(row(32'h100, 1, 1, 1, 32'h200, 8'h00, 0, 32'h0,  1, 8'h0F, 0, 32'h104, 8'h41, 8'h01));
    tbl.push_back(row(32'h100, 0, 0, 0, 32'h0,   8'h00, 0, 32'h0,  0, 8'h00, 0, 32'h104, 8'h5E, 8'h1E));
`else
    tbl.push_back(row(32'h100, 1, 1, 1, 32'h100, 8'h43, 1, 32'h80,  0, 0, 0, 32'h104, 8'h40, 8'h00));
    tbl.push_back(row(32'h100, 1, 1, 1, 32'h100, 8'h43, 1, 32'h80,  0, 0, 0, 32'h104, 8'h41, 8'h01));
    tbl.push_back(row(32'h100, 1, 0, 0, 32'h0,   8'h00, 0, 32'h0,    0, 0, 1, 32'h80,  8'h43, 8'h03));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 1, 32'h500, 0, 0, 0, 32'h4,   8'h03, 8'h03));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 1, 32'h500, 0, 0, 0, 32'h4,   8'h07, 8'h07));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 1, 32'h500, 0, 0, 0, 32'h4,   8'h0F, 8'h0F));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 1, 32'h500, 0, 0, 0, 32'h4,   8'h1F, 8'h1F));
    tbl.push_back(row(32'h7C,  1, 1, 1, 32'h7C,  8'h20, 0, 32'h500, 0, 0, 1, 32'h500, 8'h20, 8'h3F));
    tbl.push_back(row(32'h0,   1, 1, 0, 32'h178, 8'h00, 1, 32'h600, 0, 0, 0, 32'h4,   8'h7E, 8'h7E));
    tbl.push_back(row(32'h178, 1, 1, 1, 32'h7C,  8'h20, 0, 32'h500, 0, 0, 1, 32'h600, 8'h20, 8'h7E));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 0, 32'h500, 0, 0, 0, 32'h4,   8'hFC, 8'hFC));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 0, 32'h500, 0, 0, 0, 32'h4,   8'hF8, 8'hF8));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 0, 32'h500, 0, 0, 0, 32'h4,   8'hF0, 8'hF0));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 0, 32'h500, 0, 0, 0, 32'h4,   8'hE0, 8'hE0));
    tbl.push_back(row(32'h0,   1, 1, 0, 32'h8C,  8'h00, 1, 32'h700, 0, 0, 0, 32'h4,   8'hC0, 8'hC0));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 1, 32'h500, 0, 0, 0, 32'h4,   8'hC0, 8'hC0));
    tbl.push_back(row(32'h0,   1, 1, 1, 32'h7C,  8'h20, 1, 32'h500, 0, 0, 0, 32'h4,   8'h81, 8'h81));
    tbl.push_back(row(32'h8C,  1, 0, 0, 32'h0,   8'h00, 0, 32'h0,   0, 0, 1, 32'h700, 8'h20, 8'h03));
    tbl.push_back(row(32'h100, 1, 1, 0, 32'h140, 8'h00, 1, 32'h900, 0, 0, 1, 32'h80,  8'h43, 8'h03));
    tbl.push_back(row(32'h100, 1, 0, 0, 32'h0,   8'h00, 0, 32'h0,   0, 0, 0, 32'h104, 8'h43, 8'h03));
    tbl.push_back(row(32'hFFFF_FFFC, 1, 0, 0, 32'h0, 8'h00, 0, 32'h0, 0, 0, 0, 32'h0, 8'hFC, 8'h03));
`endif

    // INIT: updates hammering pc 0x100 must be ignored; ready low for 256 cycles.
    for (int i = 0; i < 256; i++) begin
      v = row(rnd_pc(), 1, 1, 1, 32'h100, 8'h40, 1, 32'h80, 1, 8'h55, 0, 0, 0, 0);
      step(v, 1'b1, 1'b0, "init", rdy);
    end

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], 1'b1, 1'b1, $sformatf("row%0d", i), rdy);

    for (int i = 0; i < 600; i++) step(rnd_vec(), 1'b1, 1'b0, "rand1", rdy);

    // Reset while running, then reset again part-way through INIT (counter at 100).
    do_reset();
    for (int i = 0; i < 100; i++) step(rnd_vec(), 1'b1, 1'b0, "init100", rdy);
    do_reset();
    rise = -1;
    for (int i = 0; i < 400 && rise < 0; i++) begin
      v = rnd_vec();
      v.uv = 1'b0;
      step(v, 1'b1, 1'b0, "reinit", rdy);
      if (rdy) rise = i;
    end
    chk("ready_rise_cycle", rise, 256);

    v = row(32'h100, 1, 0, 0, 32'h0, 8'h00, 0, 32'h0, 0, 0, 0, 32'h104, 8'h40, 8'h00);
    step(v, 1'b1, 1'b1, "reinit_lookup", rdy);

    for (int i = 0; i < 300; i++) step(rnd_vec(), 1'b1, 1'b0, "rand2", rdy);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
